// File: rtl/rle_encoder.sv
// Run-length encoder for zigzag-ordered 8x8 coefficient blocks: emits a DC symbol,
// (zero-run, level) AC pairs and EOB, one registered symbol per accepted beat at most.
module rle_encoder #(
  parameter int DW = 10,
  parameter int N  = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vld_in,
  input  logic [DW-1:0] din,
  input  logic          blk_clr,
  output logic          vld_out,
  output logic [5:0]    run,
  output logic [DW-1:0] level,
  output logic          is_dc,
  output logic          eob,
  output logic          blk_done
);

  localparam int IW = 6;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [IW-1:0] idx, idx_nxt;
  logic [IW-1:0] zcnt, zcnt_nxt;
  logic          vld_nxt, dc_nxt, eob_nxt, done_nxt;
  logic [5:0]    run_nxt;
  logic [DW-1:0] level_nxt;
  logic          din_zero;

  assign din_zero = (din == '0);

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    idx_nxt   = idx;
    zcnt_nxt  = zcnt;
    vld_nxt   = 1'b0;
    dc_nxt    = 1'b0;
    eob_nxt   = 1'b0;
    done_nxt  = 1'b0;
    run_nxt   = run;
    level_nxt = level;

    if (blk_clr) begin
      idx_nxt  = '0;
      zcnt_nxt = '0;
    end else if (vld_in) begin
      idx_nxt = (idx == LAST_IDX) ? '0 : idx + IW'(1);
      if (idx == '0) begin
        vld_nxt   = 1'b1;
        dc_nxt    = 1'b1;
        run_nxt   = '0;
        level_nxt = din;
        zcnt_nxt  = '0;
      end else if (idx == LAST_IDX) begin
        // A trailing zero closes the block as EOB; the pending run is dropped.
        vld_nxt   = 1'b1;
        done_nxt  = 1'b1;
        eob_nxt   = din_zero;
        run_nxt   = din_zero ? '0 : zcnt;
        level_nxt = din;
        zcnt_nxt  = '0;
      end else if (din_zero) begin
        zcnt_nxt = zcnt + IW'(1);
      end else begin
        vld_nxt   = 1'b1;
        run_nxt   = zcnt;
        level_nxt = din;
        zcnt_nxt  = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      zcnt     <= '0;
      vld_out  <= 1'b0;
      run      <= '0;
      level    <= '0;
      is_dc    <= 1'b0;
      eob      <= 1'b0;
      blk_done <= 1'b0;
    end else begin
      idx      <= idx_nxt;
      zcnt     <= zcnt_nxt;
      vld_out  <= vld_nxt;
      run      <= run_nxt;
      level    <= level_nxt;
      is_dc    <= dc_nxt;
      eob      <= eob_nxt;
      blk_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_rle_encoder.sv
// Self-checking bench for rle_encoder: a reference model pushes expected symbols
// (with their due cycle) into a queue, and a negedge monitor pops and compares.
module tb_rle_encoder;

  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vld_in;
  logic [DW-1:0] din;
  logic          blk_clr;
  logic          vld_out;
  logic [5:0]    run;
  logic [DW-1:0] level;
  logic          is_dc;
  logic          eob;
  logic          blk_done;

  rle_encoder #(.DW(DW), .N(64)) dut (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .din(din), .blk_clr(blk_clr),
    .vld_out(vld_out), .run(run), .level(level), .is_dc(is_dc), .eob(eob),
    .blk_done(blk_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]    run;
    logic [DW-1:0] level;
    logic          is_dc;
    logic          eob;
    logic          done;
    int            cyc;
  } sym_t;

  sym_t          sb[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            sym_cnt  = 0;
  int            base;
  int            m_idx    = 0;
  int            m_zcnt   = 0;
  logic [5:0]    last_run;
  logic [DW-1:0] last_level;
  logic [DW-1:0] coef[64];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [DW-1:0] l, input logic dc, input logic e, input logic d);
    sym_t s;
    s.run = 6'(r); s.level = l; s.is_dc = dc; s.eob = e; s.done = d; s.cyc = cyc + 1;
    sb.push_back(s);
  endtask

  // Drive one cycle of inputs and advance the reference model for it.
  task automatic beat(input logic v, input logic [DW-1:0] d, input logic clr);
    vld_in = v; din = d; blk_clr = clr;
    if (clr) begin
      m_idx = 0; m_zcnt = 0;
    end else if (v) begin
      if (m_idx == 0) begin
        push(0, d, 1'b1, 1'b0, 1'b0);
        m_zcnt = 0;
      end else if (m_idx == 63) begin
        if (d == '0) push(0, '0, 1'b0, 1'b1, 1'b1);
        else         push(m_zcnt, d, 1'b0, 1'b0, 1'b1);
        m_zcnt = 0;
      end else if (d == '0) begin
        m_zcnt++;
      end else begin
        push(m_zcnt, d, 1'b0, 1'b0, 1'b0);
        m_zcnt = 0;
      end
      m_idx = (m_idx == 63) ? 0 : m_idx + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input int gap_pct);
    for (int i = 0; i < 64; i++) begin
      while ($urandom_range(99) < gap_pct) beat(1'b0, DW'($urandom), 1'b0);
      beat(1'b1, coef[i], 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, '0, 1'b0);
  endtask

  task automatic fill_zero();
    for (int i = 0; i < 64; i++) coef[i] = '0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_run   = '0;
      last_level = '0;
    end else if (vld_out) begin
      check("symbol_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        sym_t e;
        e = sb.pop_front();
        check("sym_cycle", cyc, e.cyc);
        check("sym_run", run, e.run);
        check("sym_level", level, e.level);
        check("sym_is_dc", is_dc, e.is_dc);
        check("sym_eob", eob, e.eob);
        check("sym_blk_done", blk_done, e.done);
      end
      last_run   = run;
      last_level = level;
      sym_cnt++;
    end else begin
      check("idle_pulses", {is_dc, eob, blk_done}, 3'b000);
      check("hold_run", run, last_run);
      check("hold_level", level, last_level);
    end
  end

  initial begin
    rst_n = 1'b0; vld_in = 1'b0; din = '0; blk_clr = 1'b0;
    #12;
    check("rst_outputs", {vld_out, run, level, is_dc, eob, blk_done}, '0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All-zero block: DC(0) then EOB with blk_done 63 cycles later.
    base = sym_cnt;
    fill_zero();
    run_block(0);
    idle(2);
    check("t1_count", sym_cnt - base, 2);

    // Sparse block: (0,100,dc), (4,-3), (57,7) ending on a pair.
    base = sym_cnt;
    fill_zero();
    coef[0] = DW'(100); coef[5] = DW'(-3); coef[63] = DW'(7);
    run_block(0);
    idle(2);
    check("t2_count", sym_cnt - base, 3);

    // Dense block: 64 run-0 symbols, levels 1..64.
    base = sym_cnt;
    for (int i = 0; i < 64; i++) coef[i] = DW'(i + 1);
    run_block(0);
    idle(2);
    check("t3_count", sym_cnt - base, 64);

    // Maximum run (62) with the most negative level.
    base = sym_cnt;
    fill_zero();
    coef[0] = DW'(-5); coef[63] = 10'h200;
    run_block(0);
    idle(2);
    check("t4_count", sym_cnt - base, 2);

    // Two back-to-back blocks with random input gaps.
    base = sym_cnt;
    fill_zero();
    coef[0] = DW'(100); coef[5] = DW'(-3); coef[63] = DW'(7);
    run_block(40);
    run_block(40);
    idle(2);
    check("t5_count", sym_cnt - base, 6);

    // Abort after 20 beats; the beat coinciding with blk_clr is dropped.
    base = sym_cnt;
    for (int i = 0; i < 20; i++) beat(1'b1, (i == 0) ? DW'(11) : (i == 10) ? DW'(22) : DW'(0), 1'b0);
    beat(1'b1, DW'(33), 1'b1);
    fill_zero();
    coef[0] = DW'(44); coef[1] = DW'(1);
    run_block(0);
    idle(2);
    check("t6_count", sym_cnt - base, 5);

    // Asynchronous reset 30 beats into a block.
    base = sym_cnt;
    for (int i = 0; i < 30; i++) beat(1'b1, (i == 0) ? DW'(5) : (i == 29) ? DW'(-1) : DW'(0), 1'b0);
    vld_in = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {vld_out, run, level, is_dc, eob, blk_done}, '0);
    m_idx = 0; m_zcnt = 0;
    #1 rst_n = 1'b1;
    fill_zero();
    coef[0] = DW'(77);
    run_block(0);
    idle(2);
    check("t7_count", sym_cnt - base, 4);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
